sa_step_controller: RTL and testbench
=====================================

# sa_step_controller

Sequencer for the systolic-array datapath. It accepts a start request, steps a 4-bit step counter through 0..LAST_STEP (default 0..8), and drives that counter to the SA MUX-select decoders. It also emits per-step qualifiers (step_valid, acc_clr) and a one-cycle done pulse. It sits between the top-level control and the SA decoders, and is the only source of the decoders' `cnt` input.

## Interface
- LAST_STEP, 8, final counter value of a pass; legal range 1..(2^CNT_W − 1)
- CNT_W, 4, counter width; must match the decoder `cnt` width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  pass request; sampled only when ready=1
- stall  input  1  hold request; freezes the counter while in RUN
- ready  output  1  controller can accept start
- busy  output  1  pass in progress (state RUN)
- cnt  output  CNT_W  current step, registered; feeds the SA decoders
- step_valid  output  1  current cnt is an executed step this cycle
- acc_clr  output  1  first-step pulse; clears the SA accumulators
- done  output  1  one-cycle pulse after the last step

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Reset, asynchronous: state=IDLE, cnt=0. Outputs in reset: ready=1, busy=0, step_valid=0, acc_clr=0, done=0.
- IDLE:
  - ready=1.
  - start=1 → RUN with cnt=0.
  - start=0 → stay in IDLE, cnt held at 0.
- RUN:
  - busy=1, ready=0.
  - step_valid = !stall.
  - acc_clr = (cnt==0) && !stall, so exactly one pulse per pass regardless of stalls.
  - stall=1 → cnt and state hold.
  - stall=0 and cnt<LAST_STEP → cnt+1.
  - stall=0 and cnt==LAST_STEP → DONE, cnt←0.
- DONE:
  - done=1, busy=0, step_valid=0.
  - Next cycle → IDLE unless overridden by the macro (see Configuration).
- start while ready=0 is ignored; it is not queued.
- stall outside RUN has no effect.
- cnt never exceeds LAST_STEP and never wraps.
- ready, busy and done decode from state only. step_valid and acc_clr are combinational from state, cnt and stall.

## Timing
- start=1 sampled at edge T (ready=1) → from T+1: busy=1, cnt=0, acc_clr=1 if stall=0.
- No stall: cnt=k during cycle T+1+k for k=0..LAST_STEP. done=1 during T+2+LAST_STEP. ready=1 again at T+3+LAST_STEP.
- Default LAST_STEP=8: busy for 9 cycles, done at T+10.
- Each stalled cycle in RUN delays every later event by exactly one cycle.
- rst asserted mid-pass: outputs go to reset values immediately, without waiting for clk. First start is accepted at the first edge after rst deasserts.
- Latency from cnt change to decoder output is purely combinational, within the same cycle.

## Configuration
- Macro: SA_STEP_CTRL_BACK_TO_BACK_EN.
- Defined:
  - ready=1 also in DONE.
  - start=1 in DONE → RUN with cnt=0 directly, skipping IDLE. Back-to-back passes have a period of LAST_STEP+2 cycles.
  - done still pulses for that cycle.
- Undefined:
  - ready=0 in DONE.
  - DONE always returns to IDLE, giving a minimum pass period of LAST_STEP+3 cycles.

## Test plan
- Reset then idle: rst=1 for 3 cycles, then release → ready=1, cnt=0, busy=0, done=0. No change over 10 cycles with start=0.
- Single pass, LAST_STEP=8: start pulse at T → cnt=0..8 on T+1..T+9, acc_clr only at T+1, step_valid=1 for 9 cycles, done=1 only at T+10, ready=1 at T+11.
- Stall: stall=1 for 2 cycles while cnt=0, then for 1 cycle while cnt=5 → acc_clr asserted once (first unstalled cnt=0 cycle), step_valid=0 during stalls, done delayed by 3 cycles to T+13.
- Ignored start: start held high throughout a pass → exactly one pass.
  - Macro off: next pass begins one cycle after IDLE is re-entered.
  - Macro on: cnt=0 in the cycle after done.
- Async reset mid-pass: assert rst between edges while cnt=4 → cnt=0, busy=0, ready=1 before the next clk edge. A new start after release yields a full 0..8 sequence.
- Parameter sweep: LAST_STEP=1 and LAST_STEP=15 → cnt sequences 0,1 and 0..15 respectively. done arrives LAST_STEP+2 cycles after start, and cnt never exceeds LAST_STEP.

Source files
------------

// File: rtl/sa_step_controller_if.sv
// Handshake bundle between top-level control and the systolic-array step sequencer.
interface sa_step_controller_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             stall;
    logic             ready;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             step_valid;
    logic             acc_clr;
    logic             done;

    modport master (
        output start, stall,
        input  ready, busy, cnt, step_valid, acc_clr, done
    );

    modport slave (
        input  start, stall,
        output ready, busy, cnt, step_valid, acc_clr, done
    );
endinterface

// File: rtl/sa_step_controller.sv
// Step sequencer driving cnt 0..LAST_STEP to the SA MUX-select decoders.
// Optional SA_STEP_CTRL_BACK_TO_BACK_EN: accept start in DONE for back-to-back passes.
module sa_step_controller #(
    parameter int unsigned LAST_STEP = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_step_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_STEP);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ready;
    logic             busy;
    logic             done;
    logic             step_valid;
    logic             acc_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        step_valid = 1'b0;
        acc_clr    = 1'b0;
        case (state)
            IDLE: begin
                ready   = 1'b1;
                cnt_nxt = '0;
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                step_valid = !bus.stall;
                // Gating with stall keeps acc_clr to one pulse per pass.
                acc_clr    = (cnt == '0) && !bus.stall;
                if (!bus.stall) begin
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                cnt_nxt = '0;
`ifdef SA_STEP_CTRL_BACK_TO_BACK_EN
                ready     = 1'b1;
                state_nxt = bus.start ? RUN : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.ready      = ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.cnt        = cnt;
    assign bus.step_valid = step_valid;
    assign bus.acc_clr    = acc_clr;
endmodule

// File: tb/tb_sa_step_controller.sv
// Self-checking bench: three controllers (LAST_STEP 8, 1, 15) against a pass-level reference model.
module tb_sa_step_controller;
`ifdef SA_STEP_CTRL_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start_v;
    logic stall_v;

    always #5 clk = ~clk;

    sa_step_controller_if #(.CNT_W(4)) bus8 ();
    sa_step_controller_if #(.CNT_W(4)) bus1 ();
    sa_step_controller_if #(.CNT_W(4)) bus15 ();

    assign bus8.start  = start_v;
    assign bus8.stall  = stall_v;
    assign bus1.start  = start_v;
    assign bus1.stall  = stall_v;
    assign bus15.start = start_v;
    assign bus15.stall = stall_v;

    sa_step_controller #(.LAST_STEP(8),  .CNT_W(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    sa_step_controller #(.LAST_STEP(1),  .CNT_W(4)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
    sa_step_controller #(.LAST_STEP(15), .CNT_W(4)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

    int n_tests = 0;
    int n_fail  = 0;

    int last_of [3] = '{8, 1, 15};

    // Reference model: a pass is either in progress (with a count of executed steps) or finished.
    bit m_active [3];
    int m_steps  [3];
    bit m_done   [3];

    logic       obs_ready [3];
    logic       obs_busy  [3];
    logic       obs_done  [3];
    logic       obs_sv    [3];
    logic       obs_acc   [3];
    logic [3:0] obs_cnt   [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0;
            m_steps[i]  = 0;
            m_done[i]   = 1'b0;
        end
    endtask

    function automatic bit exp_ready(input int i);
        return !m_active[i] && (!m_done[i] || B2B);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (exp_ready(i) && start_v) begin
                m_active[i] = 1'b1;
                m_steps[i]  = 0;
                m_done[i]   = 1'b0;
            end else if (m_active[i] && !stall_v) begin
                if (m_steps[i] == last_of[i]) begin
                    m_active[i] = 1'b0;
                    m_steps[i]  = 0;
                    m_done[i]   = 1'b1;
                end else begin
                    m_steps[i]++;
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    endtask

    task automatic sample();
        obs_ready[0] = bus8.ready;  obs_busy[0] = bus8.busy;  obs_done[0] = bus8.done;
        obs_sv[0]    = bus8.step_valid;  obs_acc[0] = bus8.acc_clr;  obs_cnt[0] = bus8.cnt;
        obs_ready[1] = bus1.ready;  obs_busy[1] = bus1.busy;  obs_done[1] = bus1.done;
        obs_sv[1]    = bus1.step_valid;  obs_acc[1] = bus1.acc_clr;  obs_cnt[1] = bus1.cnt;
        obs_ready[2] = bus15.ready; obs_busy[2] = bus15.busy; obs_done[2] = bus15.done;
        obs_sv[2]    = bus15.step_valid; obs_acc[2] = bus15.acc_clr; obs_cnt[2] = bus15.cnt;
    endtask

    task automatic check_all();
        int exp_cnt;
        sample();
        for (int i = 0; i < 3; i++) begin
            exp_cnt = m_active[i] ? m_steps[i] : 0;
            check($sformatf("ready[L%0d]", last_of[i]), 32'(obs_ready[i]), 32'(exp_ready(i)));
            check($sformatf("busy[L%0d]", last_of[i]),  32'(obs_busy[i]),  32'(m_active[i]));
            check($sformatf("done[L%0d]", last_of[i]),  32'(obs_done[i]),  32'(m_done[i]));
            check($sformatf("cnt[L%0d]", last_of[i]),   32'(obs_cnt[i]),   32'(exp_cnt));
            check($sformatf("step_valid[L%0d]", last_of[i]), 32'(obs_sv[i]),
                  32'(m_active[i] && !stall_v));
            check($sformatf("acc_clr[L%0d]", last_of[i]), 32'(obs_acc[i]),
                  32'(m_active[i] && !stall_v && m_steps[i] == 0));
            if (obs_cnt[i] > 4'(last_of[i]))
                check($sformatf("cnt_bound[L%0d]", last_of[i]), 32'(obs_cnt[i]), 32'(last_of[i]));
        end
    endtask

    task automatic cycle(input bit s, input bit st);
        @(negedge clk);
        start_v = s;
        stall_v = st;
        #1;
        check_all();
        if (rst) model_reset();
        else     model_step();
    endtask

    // Assert rst between edges and verify outputs return to reset values without a clock.
    task automatic async_reset();
        @(negedge clk);
        start_v = 1'b0;
        stall_v = 1'b0;
        #1;
        check_all();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle(0, 0);
        rst = 1'b0;
    endtask

    // Start a pass at edge T, then observe cycles T+1..T+20.
    task automatic measure(input bit hold_start, input bit stall_pat,
                           output int first_done [3], output int acc8, output int second_acc8);
        bit st;
        acc8       = 0;
        second_acc8 = 0;
        for (int i = 0; i < 3; i++) first_done[i] = 0;
        cycle(1, 0);
        for (int m = 1; m <= 20; m++) begin
            st = stall_pat && (m == 1 || m == 2 || m == 8);
            cycle(hold_start, st);
            for (int i = 0; i < 3; i++)
                if (obs_done[i] === 1'b1 && first_done[i] == 0) first_done[i] = m;
            if (obs_acc[0] === 1'b1) begin
                acc8++;
                if (acc8 == 2) second_acc8 = m;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fd [3];
        int acc8;
        int acc2;
        rst     = 1'b1;
        start_v = 1'b0;
        stall_v = 1'b0;
        model_reset();

        repeat (3) cycle(0, 0);
        rst = 1'b0;
        repeat (10) cycle(0, 0);

        measure(0, 0, fd, acc8, acc2);
        check("single_done_L8", 32'(fd[0]), 32'd10);
        check("single_done_L1", 32'(fd[1]), 32'd3);
        check("single_done_L15", 32'(fd[2]), 32'd17);
        check("single_acc_clr_count", 32'(acc8), 32'd1);
        repeat (5) cycle(0, 0);

        measure(0, 1, fd, acc8, acc2);
        check("stall_done_L8", 32'(fd[0]), 32'd13);
        check("stall_acc_clr_count", 32'(acc8), 32'd1);
        repeat (5) cycle(0, 0);

        measure(1, 0, fd, acc8, acc2);
        check("held_start_done_L8", 32'(fd[0]), 32'd10);
        check("held_start_second_pass", 32'(acc2), B2B ? 32'd11 : 32'd12);
        repeat (20) cycle(0, 0);

        cycle(1, 0);
        repeat (4) cycle(0, 0);
        async_reset();
        measure(0, 0, fd, acc8, acc2);
        check("post_reset_done_L8", 32'(fd[0]), 32'd10);
        check("post_reset_acc_clr_count", 32'(acc8), 32'd1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) async_reset();
            else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
